// File: rtl/cpu_line_buffer_pkg.sv
// Shared types and constants for the single-entry CPU line buffer.
// Line geometry, beat geometry, FSM state encoding and address helpers.
package cpu_line_buffer_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_W     = 256;
    localparam int unsigned BEAT_W     = 64;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BEATS      = LINE_W / BEAT_W;
    localparam int unsigned OFF_W      = $clog2(LINE_W / 8);
    localparam int unsigned BEAT_CNT_W = $clog2(BEATS);
    localparam int unsigned TAG_W      = ADDR_W - OFF_W;
    localparam int unsigned WIDX_W     = OFF_W - 2;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [TAG_W-1:0]  tag_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        WB   = 2'd2,
        FILL = 2'd3
    } lb_state_t;

    // Line tag of a CPU byte address.
    function automatic tag_t addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFF_W];
    endfunction

    // Line-aligned burst address for a tag.
    function automatic logic [ADDR_W-1:0] line_addr(input tag_t tag);
        return {tag, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cpu_line_buffer_datapath.sv
// Line buffer storage: valid/dirty/tag/data registers, fill-beat capture,
// byte-enable write merge, CPU word select and write-back beat select.
// Ports:
//   clk, rst            clock, async active-high reset
//   addr_i/be_i/wdata_i CPU address, byte lanes, lane-aligned write data
//   rdata_beat_i        incoming fill beat, captured at cap_beat_i when cap_en_i
//   fill_done_i         last fill beat: mark valid, load tag, clear dirty
//   wb_done_i           last write-back beat: clear dirty
//   wr_en_i             merge CPU write into the addressed word
//   rd_beat_i           beat index for beat_sel_c
//   valid_o/dirty_o/tag_o  registered line state
//   hit_c               resident line matches addr_i
//   word_next_c         addressed word of the next-cycle line contents
//   beat_sel_c          beat rd_beat_i of the current line
module line_buffer_datapath
    import cpu_line_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [3:0]            be_i,
    input  logic [WORD_W-1:0]     wdata_i,
    input  logic [BEAT_W-1:0]     rdata_beat_i,
    input  logic [BEAT_CNT_W-1:0] cap_beat_i,
    input  logic                  cap_en_i,
    input  logic                  fill_done_i,
    input  logic                  wb_done_i,
    input  logic                  wr_en_i,
    input  logic [BEAT_CNT_W-1:0] rd_beat_i,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic                  hit_c,
    output logic [WORD_W-1:0]     word_next_c,
    output logic [BEAT_W-1:0]     beat_sel_c
);

    line_t             data_q, data_d;
    logic              valid_q, valid_d;
    logic              dirty_q, dirty_d;
    tag_t              tag_q, tag_d;
    logic [WIDX_W-1:0] widx;
    logic              unused_addr_bits;

    assign widx             = addr_i[OFF_W-1:2];
    assign unused_addr_bits = ^addr_i[1:0];

    // Next line state: fill capture, fill/write-back completion, CPU write merge.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        if (cap_en_i) begin
            data_d[BEAT_W*cap_beat_i +: BEAT_W] = rdata_beat_i;
        end
        if (fill_done_i) begin
            valid_d = 1'b1;
            tag_d   = addr_tag(addr_i);
            dirty_d = 1'b0;
        end
        if (wb_done_i) begin
            dirty_d = 1'b0;
        end
        if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    data_d[WORD_W*widx + 8*b +: 8] = wdata_i[8*b +: 8];
                end
            end
            // An all-zero byte enable leaves the line clean.
            if (be_i != 4'b0000) begin
                dirty_d = 1'b1;
            end
        end
    end

    // Line state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o     = valid_q;
    assign dirty_o     = dirty_q;
    assign tag_o       = tag_q;
    assign hit_c       = valid_q && (tag_q == addr_tag(addr_i));
    // Taken from data_d so the word is correct on the edge that completes a fill.
    assign word_next_c = data_d[WORD_W*widx +: WORD_W];
    assign beat_sel_c  = data_q[BEAT_W*rd_beat_i +: BEAT_W];

endmodule

// File: rtl/cpu_line_buffer.sv
// Single-entry write-back line buffer between the CPU memory port and a
// 64-bit burst memory port. Hits answer one cycle after the request is
// sampled; misses write back a dirty line, then fill the new line in beats.
// Ports:
//   clk, rst                         clock, async active-high reset
//   mem_address/read/write           CPU request (level, held until mem_resp)
//   mem_byte_enable, mem_wdata       CPU write lanes and data
//   mem_rdata, mem_resp              CPU read word and one-cycle completion
//   pmem_address/read/write/wdata    burst request towards physical memory
//   pmem_rdata, pmem_resp            burst beat return / acceptance
module cpu_line_buffer
    import cpu_line_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        mem_byte_enable,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic [ADDR_W-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    lb_state_t             state_q, state_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic                  cap_en, fill_done, wb_done, wr_en;
    logic                  req, last_beat;
    logic                  valid, dirty, hit_c;
    tag_t                  tag;
    logic [WORD_W-1:0]     word_next_c;
    logic [BEAT_W-1:0]     beat_sel_c;

    logic [WORD_W-1:0]     mem_rdata_q, mem_rdata_d;
    logic                  mem_resp_q, pmem_read_q, pmem_write_q;
    logic [ADDR_W-1:0]     pmem_address_q, pmem_address_d;
    logic [BEAT_W-1:0]     pmem_wdata_q, pmem_wdata_d;

    assign req       = mem_read | mem_write;
    assign last_beat = (beat_q == BEAT_CNT_W'(BEATS - 1));

    line_buffer_datapath u_dp (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (mem_address),
        .be_i         (mem_byte_enable),
        .wdata_i      (mem_wdata),
        .rdata_beat_i (pmem_rdata),
        .cap_beat_i   (beat_q),
        .cap_en_i     (cap_en),
        .fill_done_i  (fill_done),
        .wb_done_i    (wb_done),
        .wr_en_i      (wr_en),
        .rd_beat_i    (beat_d),
        .valid_o      (valid),
        .dirty_o      (dirty),
        .tag_o        (tag),
        .hit_c        (hit_c),
        .word_next_c  (word_next_c),
        .beat_sel_c   (beat_sel_c)
    );

    // Next state, beat counter and datapath strobes.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        cap_en    = 1'b0;
        fill_done = 1'b0;
        wb_done   = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit_c) begin
                        state_d = RESP;
                    end else if (valid && dirty) begin
                        state_d = WB;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            RESP: begin
                // Write merges on the edge leaving RESP; read+write counts as write.
                wr_en   = mem_write;
                state_d = IDLE;
            end
            WB: begin
                if (pmem_resp) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        wb_done = 1'b1;
                        state_d = FILL;
                    end else begin
                        beat_d = beat_q + BEAT_CNT_W'(1);
                    end
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    cap_en = 1'b1;
                    if (last_beat) begin
                        beat_d    = '0;
                        fill_done = 1'b1;
                        state_d   = RESP;
                    end else begin
                        beat_d = beat_q + BEAT_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming state, so every output is a register.
    always_comb begin
        pmem_address_d = '0;
        case (state_d)
            WB:      pmem_address_d = line_addr(tag);
            FILL:    pmem_address_d = line_addr(addr_tag(mem_address));
            default: pmem_address_d = '0;
        endcase
        pmem_wdata_d = (state_d == WB) ? beat_sel_c : '0;
        mem_rdata_d  = (state_d == RESP) ? word_next_c : mem_rdata_q;
    end

    // State, beat counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            mem_resp_q     <= 1'b0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            mem_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            mem_resp_q     <= (state_d == RESP);
            pmem_read_q    <= (state_d == FILL);
            pmem_write_q   <= (state_d == WB);
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            mem_rdata_q    <= mem_rdata_d;
        end
    end

    assign mem_rdata    = mem_rdata_q;
    assign mem_resp     = mem_resp_q;
    assign pmem_address = pmem_address_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule
